booth_final_adder: RTL and testbench

Two-stage pipelined carry-propagate adder that resolves the redundant sum/carry vector pair from the partial-product 3:2 compression stage into the final binary product word. It sits directly downstream of the compressor tree and is the last arithmetic stage of the Booth multiplier datapath. It adds valid/ready flow control so the multiplier can stall against a slow consumer. It also keeps a count of completed results for debug.

---
 rtl/booth_final_adder_if.sv | 26 ++
 rtl/booth_final_adder.sv | 87 ++++++++
 tb/tb_booth_final_adder.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_final_adder_if.sv
`default_nettype none
// ---- booth_final_adder_if : producer/consumer bundle for the final adder  (rev 1.0) ----
interface booth_final_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic [15:0]      done_count;

  modport master (
    output in_valid, sum_in, carry_in, out_ready,
    input  in_ready, out_valid, result, cout, done_count
  );

  modport slave (
    input  in_valid, sum_in, carry_in, out_ready,
    output in_ready, out_valid, result, cout, done_count
  );
endinterface
`default_nettype wire

// File: rtl/booth_final_adder.sv
`default_nettype none
// ---- booth_final_adder : 2-stage pipelined CPA resolving sum/carry vectors, valid/ready  (rev 1.0) ----
module booth_final_adder #(
  parameter int WIDTH = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  booth_final_adder_if.slave bus
);
  localparam int LO_W = WIDTH / 2;
  localparam int HI_W = WIDTH - LO_W;

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("booth_final_adder: WIDTH must be even and >= 4");
  end

  logic [LO_W:0]      s1_lo;
  logic [HI_W-1:0]    s1_hi_sum;
  logic [HI_W-1:0]    s1_hi_carry;
  logic               s1_valid;

  logic [WIDTH-1:0]   s2_result;
  logic               s2_cout;
  logic               s2_valid;
  logic [15:0]        done_count;

  logic               s2_adv;
  logic               s1_adv;
  logic               in_xfer;
  logic               out_xfer;
  logic [LO_W:0]      lo_sum;
  logic [HI_W:0]      hi_sum;

  // Ready looks only at pipeline state and out_ready, never at in_valid.
  assign s2_adv   = !s2_valid || bus.out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_xfer  = bus.in_valid && s1_adv;
  assign out_xfer = s2_valid && bus.out_ready;

  assign lo_sum = {1'b0, bus.sum_in[LO_W-1:0]} + {1'b0, bus.carry_in[LO_W-1:0]};
  assign hi_sum = {1'b0, s1_hi_sum} + {1'b0, s1_hi_carry} + {{HI_W{1'b0}}, s1_lo[LO_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_lo       <= '0;
      s1_hi_sum   <= '0;
      s1_hi_carry <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_xfer;
      if (in_xfer) begin
        s1_lo       <= lo_sum;
        s1_hi_sum   <= bus.sum_in[WIDTH-1:LO_W];
        s1_hi_carry <= bus.carry_in[WIDTH-1:LO_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_cout   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= {hi_sum[HI_W-1:0], s1_lo[LO_W-1:0]};
        s2_cout   <= hi_sum[HI_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_count <= 16'd0;
    end else if (out_xfer) begin
      done_count <= done_count + 16'd1;
    end
  end

  assign bus.in_ready   = s1_adv;
  assign bus.out_valid  = s2_valid;
  assign bus.result     = s2_result;
  assign bus.cout       = s2_cout;
  assign bus.done_count = done_count;
endmodule
`default_nettype wire

// File: tb/tb_booth_final_adder.sv
`default_nettype none
// ---- tb_booth_final_adder : directed + scoreboard bench for booth_final_adder  (rev 1.0) ----
module tb_booth_final_adder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [15:0] exp_done = 16'd0;

  booth_final_adder_if #(.WIDTH(16)) bus ();
  booth_final_adder #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.sum_in    = 16'h0;
    bus.carry_in  = 16'h0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_done = 16'd0;
  endtask

  task automatic test_power_on();
    bus.in_valid = 1'b0; bus.sum_in = 16'h0; bus.carry_in = 16'h0; bus.out_ready = 1'b0;
    rst = 1'b1;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 16'h0 ||
        bus.cout !== 1'b0 || bus.done_count !== 16'h0) begin
      failures++;
      $display("FAIL power_on: ov=%b ir=%b res=%h cout=%b cnt=%h, want ov=0 ir=1 res=0 cout=0 cnt=0",
               bus.out_valid, bus.in_ready, bus.result, bus.cout, bus.done_count);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_low_high_carry();
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b1; bus.sum_in = 16'h00FF; bus.carry_in = 16'h0002;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL lohi_ready: in_ready=%b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL lohi_latency: out_valid=%b want 0 after one edge", bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 16'h0101 || bus.cout !== 1'b0) begin
      failures++;
      $display("FAIL lohi_result: ov=%b res=%h cout=%b want ov=1 res=0101 cout=0",
               bus.out_valid, bus.result, bus.cout);
    end
    tick();
    exp_done = exp_done + 16'd1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.done_count !== exp_done) begin
      failures++;
      $display("FAIL lohi_drain: ov=%b cnt=%h want ov=0 cnt=%h", bus.out_valid, bus.done_count, exp_done);
    end
  endtask

  task automatic test_wrap();
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b1; bus.sum_in = 16'hFFFF; bus.carry_in = 16'h0002;
    tick();
    bus.sum_in = 16'h8000; bus.carry_in = 16'h8000;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 16'h0001 || bus.cout !== 1'b1) begin
      failures++;
      $display("FAIL wrap_ffff: ov=%b res=%h cout=%b want ov=1 res=0001 cout=1",
               bus.out_valid, bus.result, bus.cout);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 16'h0000 || bus.cout !== 1'b1) begin
      failures++;
      $display("FAIL wrap_8000: ov=%b res=%h cout=%b want ov=1 res=0000 cout=1",
               bus.out_valid, bus.result, bus.cout);
    end
    tick();
    exp_done = exp_done + 16'd2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.done_count !== exp_done) begin
      failures++;
      $display("FAIL wrap_count: ov=%b cnt=%h want ov=0 cnt=%h", bus.out_valid, bus.done_count, exp_done);
    end
  endtask

  task automatic test_back_pressure();
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b1; bus.sum_in = 16'h0001; bus.carry_in = 16'h0002;
    tick();
    bus.sum_in = 16'h0010; bus.carry_in = 16'h0020;
    tick();
    bus.sum_in = 16'h0100; bus.carry_in = 16'h0200;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_full_ready: in_ready=%b want 0 with two held", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== 16'h0003) begin
      failures++;
      $display("FAIL bp_stall: ir=%b ov=%b res=%h want ir=0 ov=1 res=0003",
               bus.in_ready, bus.out_valid, bus.result);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_ready: in_ready=%b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 16'h0030) begin
      failures++;
      $display("FAIL bp_second: ov=%b res=%h want ov=1 res=0030", bus.out_valid, bus.result);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 16'h0300 || bus.cout !== 1'b0) begin
      failures++;
      $display("FAIL bp_third: ov=%b res=%h cout=%b want ov=1 res=0300 cout=0",
               bus.out_valid, bus.result, bus.cout);
    end
    tick();
    exp_done = exp_done + 16'd3;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.done_count !== exp_done) begin
      failures++;
      $display("FAIL bp_count: ov=%b cnt=%h want ov=0 cnt=%h (no loss, no dup)",
               bus.out_valid, bus.done_count, exp_done);
    end
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b1; bus.sum_in = 16'h1234; bus.carry_in = 16'h1111;
    tick();
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.done_count !== exp_done) begin
      failures++;
      $display("FAIL rst_prefill: ov=%b ir=%b cnt=%h want ov=1 ir=0 cnt=%h",
               bus.out_valid, bus.in_ready, bus.done_count, exp_done);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 16'h0 ||
        bus.cout !== 1'b0 || bus.done_count !== 16'h0) begin
      failures++;
      $display("FAIL rst_async: ov=%b ir=%b res=%h cout=%b cnt=%h want ov=0 ir=1 res=0 cout=0 cnt=0",
               bus.out_valid, bus.in_ready, bus.result, bus.cout, bus.done_count);
    end
    tick();
    rst = 1'b0;
    exp_done = 16'd0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.done_count !== 16'h0) begin
      failures++;
      $display("FAIL rst_discard: ov=%b cnt=%h want ov=0 cnt=0", bus.out_valid, bus.done_count);
    end
  endtask

  task automatic test_streaming();
    logic [16:0] q[$];
    logic [16:0] e;
    logic [15:0] s;
    logic [15:0] c;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    do_reset();
    s = 16'($urandom);
    c = 16'($urandom);
    while (got < 1000 && cyc < 20000) begin
      tick();
      bus.in_valid  = (sent < 1000);
      bus.sum_in    = s;
      bus.carry_in  = c;
      bus.out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back({1'b0, s} + {1'b0, c});
        sent++;
        s = 16'($urandom);
        c = 16'($urandom);
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL stream_extra: result=%h with empty scoreboard", bus.result);
        end else begin
          e = q.pop_front();
          if ({bus.cout, bus.result} !== e) begin
            failures++;
            $display("FAIL stream_data #%0d: cout=%b res=%h want cout=%b res=%h",
                     got, bus.cout, bus.result, e[16], e[15:0]);
          end
        end
        got++;
      end
      cyc++;
    end
    checks++;
    if (got != 1000) begin
      failures++; $display("FAIL stream_timeout: got %0d results want 1000", got);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.done_count !== 16'd1000) begin
      failures++; $display("FAIL stream_count: cnt=%0d want 1000", bus.done_count);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    bus.out_ready = 1'b1;
    bus.sum_in = 16'h0005;
    bus.carry_in = 16'h0003;
    for (int i = 1; i <= 65539; i++) begin
      bus.in_valid = (i <= 65537);
      tick();
      if (i == 65537) begin
        checks++;
        if (bus.done_count !== 16'hFFFF) begin
          failures++; $display("FAIL cnt_ffff: cnt=%h want FFFF", bus.done_count);
        end
      end
    end
    checks++;
    if (bus.done_count !== 16'h0001 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL cnt_wrap: cnt=%h ov=%b want cnt=0001 ov=0", bus.done_count, bus.out_valid);
    end
  endtask

  initial begin
    test_power_on();
    test_low_high_carry();
    test_wrap();
    test_back_pressure();
    test_reset();
    test_streaming();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
